// File: rtl/psum_sat_writeback.sv
// rtl/psum_sat_writeback.sv - shared round/shift/saturate writeback for psum accumulator lanes
module psum_sat_writeback #(
   parameter int N_REQ     = 4,
   parameter int L_DATAIN  = 24,
   parameter int L_DATAOUT = 16,
   parameter int L_SHIFT   = 4,
   parameter int L_ADDR    = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [L_SHIFT-1:0]            cfg_shift,
   input  logic [L_ADDR:0]               cfg_len,
   input  logic [N_REQ*L_ADDR-1:0]       cfg_base,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*L_DATAIN-1:0]     req_data,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [L_DATAOUT-1:0]          out_data,
   output logic [L_ADDR-1:0]             out_addr,
   output logic [$clog2(N_REQ)-1:0]      out_lane,
   output logic [15:0]                   sat_cnt,
   output logic [N_REQ-1:0]              lane_done,
   output logic                          busy
);

   localparam int L_LANE = $clog2(N_REQ);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                     state_q;
   logic [L_SHIFT-1:0]         shift_q;
   logic [L_ADDR:0]            len_q;
   logic [L_ADDR-1:0]          addr_q [N_REQ];
   logic [L_ADDR:0]            cnt_q  [N_REQ];
   logic [N_REQ-1:0]           done_q;
   logic [L_LANE-1:0]          ptr_q;

   logic                       s1_vld_q;
   logic signed [L_DATAIN-1:0] s1_psum_q;
   logic [L_LANE-1:0]          s1_lane_q;
   logic [L_ADDR-1:0]          s1_addr_q;

   logic                       s2_vld_q;
   logic [L_DATAOUT-1:0]       out_data_q;
   logic [L_ADDR-1:0]          out_addr_q;
   logic [L_LANE-1:0]          out_lane_q;
   logic [15:0]                sat_cnt_q;

   logic signed [L_DATAIN-1:0] psum_arr [N_REQ];
   logic [L_ADDR-1:0]          base_arr [N_REQ];

   logic                       s2_load;
   logic                       s1_load_ok;
   logic [N_REQ-1:0]           elig;
   logic [N_REQ-1:0]           rot;
   logic                       found;
   logic [L_LANE-1:0]          off;
   logic [L_LANE:0]            sum;
   logic [L_LANE-1:0]          gnt_idx;
   logic                       grant;

   logic signed [L_DATAIN:0]   wide;
   logic signed [L_DATAIN:0]   rnd;
   logic signed [L_DATAIN:0]   r;
   logic                       clip;
   logic [L_DATAOUT-1:0]       res;

   // Split the packed per-lane buses into arrays
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         psum_arr[i] = req_data[i*L_DATAIN +: L_DATAIN];
         base_arr[i] = cfg_base[i*L_ADDR +: L_ADDR];
      end
   end

   assign s2_load    = !s2_vld_q || out_ready;
   assign s1_load_ok = !s1_vld_q || s2_load;

   // Round-robin pick: rotate eligibility so bit 0 is the pointer lane, take lowest set bit
   always_comb begin
      elig    = req_valid & ~done_q;
      rot     = N_REQ'({elig, elig} >> ptr_q);
      found   = |elig;
      off     = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (rot[k]) off = L_LANE'(k);
      end
      sum     = {1'b0, ptr_q} + {1'b0, off};
      gnt_idx = (sum >= (L_LANE+1)'(N_REQ)) ? L_LANE'(sum - (L_LANE+1)'(N_REQ)) : sum[L_LANE-1:0];
      grant   = (state_q == RUN) && found && s1_load_ok;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant && (gnt_idx == L_LANE'(i));
      end
   end

   // Round half up, arithmetic shift, clip to the output range; one extra bit so the add cannot wrap
   always_comb begin
      wide = {s1_psum_q[L_DATAIN-1], s1_psum_q};
      rnd  = (shift_q == '0) ? '0 : ((L_DATAIN+1)'(1) << (shift_q - L_SHIFT'(1)));
      r    = (wide + rnd) >>> shift_q;
      clip = !((&r[L_DATAIN:L_DATAOUT-1]) || !(|r[L_DATAIN:L_DATAOUT-1]));
      if (clip) res = r[L_DATAIN] ? {1'b1, {(L_DATAOUT-1){1'b0}}} : {1'b0, {(L_DATAOUT-1){1'b1}}};
      else      res = r[L_DATAOUT-1:0];
   end

   // Control FSM plus per-lane address/count bookkeeping and the arbitration pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         len_q   <= '0;
         done_q  <= '0;
         ptr_q   <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            addr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  shift_q <= cfg_shift;
                  len_q   <= cfg_len;
                  done_q  <= {N_REQ{cfg_len == '0}};
                  for (int i = 0; i < N_REQ; i++) begin
                     addr_q[i] <= base_arr[i];
                     cnt_q[i]  <= '0;
                  end
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (grant) begin
                  cnt_q[gnt_idx]  <= cnt_q[gnt_idx] + (L_ADDR+1)'(1);
                  addr_q[gnt_idx] <= addr_q[gnt_idx] + L_ADDR'(1);
                  if ((cnt_q[gnt_idx] + (L_ADDR+1)'(1)) == len_q) done_q[gnt_idx] <= 1'b1;
                  ptr_q <= (gnt_idx == L_LANE'(N_REQ-1)) ? '0 : gnt_idx + L_LANE'(1);
               end
               if ((&done_q) && !s1_vld_q && !s2_vld_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Two-stage stallable pipeline: S1 captures the granted psum, S2 holds the presented result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q   <= 1'b0;
         s1_psum_q  <= '0;
         s1_lane_q  <= '0;
         s1_addr_q  <= '0;
         s2_vld_q   <= 1'b0;
         out_data_q <= '0;
         out_addr_q <= '0;
         out_lane_q <= '0;
         sat_cnt_q  <= '0;
      end else begin
         if (grant) begin
            s1_vld_q  <= 1'b1;
            s1_psum_q <= psum_arr[gnt_idx];
            s1_lane_q <= gnt_idx;
            s1_addr_q <= addr_q[gnt_idx];
         end else if (s1_vld_q && s2_load) begin
            s1_vld_q  <= 1'b0;
         end
         if (s2_load) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               out_data_q <= res;
               out_addr_q <= s1_addr_q;
               out_lane_q <= s1_lane_q;
               if (clip && (sat_cnt_q != '1)) sat_cnt_q <= sat_cnt_q + 16'd1;
            end
         end
         if ((state_q == IDLE) && start) sat_cnt_q <= '0;
      end
   end

   assign out_valid = s2_vld_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_lane  = out_lane_q;
   assign sat_cnt   = sat_cnt_q;
   assign lane_done = done_q;
   assign busy      = (state_q == RUN);

endmodule
